control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control FSM directly upstream of the RV64I datapath; generates every datapath control strobe.
- Sequences FETCH → DECODE → EXECUTE (→ MEMWB for loads) from the IR opcode fed back by the datapath.
- Counts retired instructions and exposes FSM state for debug.

Parameters:
INSTRET_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_WIDTH)

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  fetch enable; 0 holds FSM in FETCH without loading IR
opcode  input  7  IR[6:0] from datapath
WE_RF  output  1  register-file write enable
WE_MEM  output  1  data-memory write enable
RF_din_sel  output  2  00 DM_out, 01 ALU result, 10 PC+4 (primary adder), 11 PC+imm (secondary adder)
ULA_din2_sel  output  1  0 rs2, 1 extended immediate
load_pc  output  1  PC update strobe
load_ir  output  1  IR load strobe
pc_next_sel  output  1  1 = take secondary-adder target (PC block gates branches with flags)
pc_adder_sel  output  1  0 secondary-adder base = PC, 1 = rs1 (JALR)
halted  output  1  FSM in HALT (optional feature)
state  output  3  encoded state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMWB, 7 HALT
instret  output  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset: next state FETCH, instret=0. While reset=1, all control outputs forced to 0 (state output reads 0).
- Outputs are combinational from current state and opcode. Registered elements: state and instret only.
- FETCH: load_ir=run; all other strobes 0. run=1 → DECODE, else remain.
- DECODE: all strobes 0; opcode now valid, RF/immediate settle.
  - Legal opcode → EXECUTE.
  - Illegal opcode → EXECUTE as NOP (see Optional Feature).
- EXECUTE, by opcode:
  - R 0110011 / OP-32 0111011: WE_RF=1, RF_din_sel=01, ULA_din2_sel=0, load_pc=1 → FETCH.
  - I-ALU 0010011 / OP-IMM-32 0011011 / LUI 0110111: WE_RF=1, RF_din_sel=01, ULA_din2_sel=1, load_pc=1 → FETCH.
  - AUIPC 0010111: WE_RF=1, RF_din_sel=11, pc_adder_sel=0, pc_next_sel=0, load_pc=1 → FETCH.
  - STORE 0100011: WE_MEM=1, ULA_din2_sel=1, load_pc=1 → FETCH.
  - LOAD 0000011: ULA_din2_sel=1, no writes → MEMWB.
  - BRANCH 1100011: ULA_din2_sel=0, pc_next_sel=1, load_pc=1 → FETCH.
  - JAL 1101111: WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=0, load_pc=1 → FETCH.
  - JALR 1100111: same as JAL but pc_adder_sel=1, ULA_din2_sel=1.
  - Illegal: load_pc=1 only (NOP) → FETCH.
- MEMWB: ULA_din2_sel=1 held (address stable), WE_RF=1, RF_din_sel=00, load_pc=1 → FETCH.
- Latency: loads 4 cycles; all other instructions 3 cycles (run held high).
- instret increments by 1 on every cycle with load_pc=1; wraps to 0 past all-ones.
- Reset mid-instruction: no WE_RF/WE_MEM/load_pc in the reset cycle; restart at FETCH.
- Unused states 4–6: next state FETCH, outputs 0.
- run is sampled only in FETCH; deasserting it mid-instruction does not abort the instruction.

Optional Feature:
- Macro CONTROL_HALT_ON_ILLEGAL_EN.
- Defined: illegal opcode in DECODE → HALT. HALT holds all strobes 0, halted=1, instret frozen; exits only via reset.
- Undefined: illegal opcode executes as NOP (PC advances, instret increments); HALT unreachable; halted tied 0.

Test Plan:
- Reset, run=1, opcode=0110011: state sequence 0,1,2,0; in EXECUTE WE_RF=1, RF_din_sel=01, load_pc=1; instret=1 after cycle 3.
- opcode=0000011: EXECUTE all writes 0, then MEMWB WE_RF=1, RF_din_sel=00, load_pc=1; 4 cycles/instr; 5 back-to-back loads → instret=5 at cycle 20.
- opcode=1100111 (JALR): EXECUTE WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=1, ULA_din2_sel=1.
- run=0 for 5 cycles after reset: state=0, load_ir=0, instret=0; raise run → load_ir=1 same cycle, DECODE next.
- opcode=1111111: macro undefined → NOP with load_pc=1, instret+1. Macro defined → state=7, halted=1, outputs 0 for 10 cycles; reset → state=0.
- Assert reset during EXECUTE of a STORE: WE_MEM=0 that cycle, next state FETCH, instret=0; INSTRET_WIDTH=4 with 16 retirements → instret wraps to 0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle RV64I control FSM: FETCH, DECODE, EXECUTE, MEMWB (+ HALT).
// Optional macro CONTROL_HALT_ON_ILLEGAL_EN: illegal opcode halts the FSM.
module control_unit #(
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     run,
   input  logic [6:0]               opcode,
   output logic                     WE_RF,
   output logic                     WE_MEM,
   output logic [1:0]               RF_din_sel,
   output logic                     ULA_din2_sel,
   output logic                     load_pc,
   output logic                     load_ir,
   output logic                     pc_next_sel,
   output logic                     pc_adder_sel,
   output logic                     halted,
   output logic [2:0]               state,
   output logic [INSTRET_WIDTH-1:0] instret
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXECUTE = 3'd2;
   localparam logic [2:0] S_MEMWB   = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd7;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_R32    = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [2:0]               state_q, state_d;
   logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

   logic       legal;
   logic       we_rf_c, we_mem_c, din2_c, ld_pc_c, ld_ir_c;
   logic       pcn_c, pca_c;
   logic [1:0] rfs_c;

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_R32, OP_IMM, OP_IMM32, OP_LUI, OP_AUIPC,
         OP_STORE, OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR:
            legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      we_rf_c  = 1'b0;
      we_mem_c = 1'b0;
      rfs_c    = 2'b00;
      din2_c   = 1'b0;
      ld_pc_c  = 1'b0;
      ld_ir_c  = 1'b0;
      pcn_c    = 1'b0;
      pca_c    = 1'b0;
      state_d  = S_FETCH;
      case (state_q)
         S_FETCH: begin
            ld_ir_c = run;
            state_d = run ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
`ifdef CONTROL_HALT_ON_ILLEGAL_EN
            state_d = legal ? S_EXECUTE : S_HALT;
`else
            state_d = S_EXECUTE;
`endif
         end
         S_EXECUTE: begin
            ld_pc_c = 1'b1;
            state_d = S_FETCH;
            case (opcode)
               OP_R, OP_R32: begin
                  we_rf_c = 1'b1;
                  rfs_c   = 2'b01;
               end
               OP_IMM, OP_IMM32, OP_LUI: begin
                  we_rf_c = 1'b1;
                  rfs_c   = 2'b01;
                  din2_c  = 1'b1;
               end
               OP_AUIPC: begin
                  we_rf_c = 1'b1;
                  rfs_c   = 2'b11;
               end
               OP_STORE: begin
                  we_mem_c = 1'b1;
                  din2_c   = 1'b1;
               end
               // Address computed now, write-back happens in MEMWB.
               OP_LOAD: begin
                  din2_c  = 1'b1;
                  ld_pc_c = 1'b0;
                  state_d = S_MEMWB;
               end
               OP_BRANCH: begin
                  pcn_c = 1'b1;
               end
               OP_JAL: begin
                  we_rf_c = 1'b1;
                  rfs_c   = 2'b10;
                  pcn_c   = 1'b1;
               end
               OP_JALR: begin
                  we_rf_c = 1'b1;
                  rfs_c   = 2'b10;
                  pcn_c   = 1'b1;
                  pca_c   = 1'b1;
                  din2_c  = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEMWB: begin
            we_rf_c = 1'b1;
            rfs_c   = 2'b00;
            din2_c  = 1'b1;
            ld_pc_c = 1'b1;
            state_d = S_FETCH;
         end
`ifdef CONTROL_HALT_ON_ILLEGAL_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Reset overrides every strobe in the same cycle it is seen.
   always_comb begin
      WE_RF        = we_rf_c  & ~reset;
      WE_MEM       = we_mem_c & ~reset;
      RF_din_sel   = reset ? 2'b00 : rfs_c;
      ULA_din2_sel = din2_c   & ~reset;
      load_pc      = ld_pc_c  & ~reset;
      load_ir      = ld_ir_c  & ~reset;
      pc_next_sel  = pcn_c    & ~reset;
      pc_adder_sel = pca_c    & ~reset;
      state        = reset ? S_FETCH : state_q;
   end

`ifdef CONTROL_HALT_ON_ILLEGAL_EN
   assign halted = (state_q == S_HALT) & ~reset;
`else
   assign halted = 1'b0;
`endif

   assign instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, load_pc};
   assign instret   = instret_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   logic unused_legal;
   assign unused_legal = legal;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit (INSTRET_WIDTH=4 to exercise wrap).
// Honours CONTROL_HALT_ON_ILLEGAL_EN when defined for the build.
module tb_control_unit;

   localparam int W = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_R32    = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ILL    = 7'b1111111;

   logic         CLK = 1'b0;
   logic         reset = 1'b1;
   logic         run = 1'b0;
   logic [6:0]   opcode = 7'd0;
   logic         WE_RF, WE_MEM, ULA_din2_sel, load_pc, load_ir;
   logic         pc_next_sel, pc_adder_sel, halted;
   logic [1:0]   RF_din_sel;
   logic [2:0]   state;
   logic [W-1:0] instret;

   control_unit #(.INSTRET_WIDTH(W)) dut (
      .CLK(CLK), .reset(reset), .run(run), .opcode(opcode),
      .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
      .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc),
      .load_ir(load_ir), .pc_next_sel(pc_next_sel),
      .pc_adder_sel(pc_adder_sel), .halted(halted),
      .state(state), .instret(instret)
   );

   always #5 CLK = ~CLK;

   // strb = {WE_RF,WE_MEM,RF_din_sel,din2,load_pc,load_ir,pcn,pca,halted}
   typedef struct packed {
      logic [2:0]   st;
      logic [9:0]   strb;
      logic [W-1:0] ins;
   } exp_t;

   exp_t         exp_q[$];
   logic [2:0]   m_st;
   logic [W-1:0] m_ins;
   int           n_tests = 0;
   int           n_fail  = 0;

`ifdef CONTROL_HALT_ON_ILLEGAL_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OP_R, OP_R32, OP_IMM, OP_IMM32, OP_LUI, OP_AUIPC,
                        OP_STORE, OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR};
   endfunction

   // Reference strobe table: {we_rf,we_mem,rfs,din2,ldpc,ldir,pcn,pca,hlt}
   function automatic logic [9:0] ref_strb(input logic [2:0] st,
                                           input logic [6:0] op,
                                           input logic rn);
      logic [9:0] v;
      v = 10'b0;
      if (st == 3'd0) v = {6'b0, rn, 3'b0};
      else if (st == 3'd2) begin
         if (op == OP_R || op == OP_R32)       v = 10'b1_0_01_0_1_0_0_0_0;
         else if (op == OP_IMM || op == OP_IMM32 || op == OP_LUI)
                                               v = 10'b1_0_01_1_1_0_0_0_0;
         else if (op == OP_AUIPC)              v = 10'b1_0_11_0_1_0_0_0_0;
         else if (op == OP_STORE)              v = 10'b0_1_00_1_1_0_0_0_0;
         else if (op == OP_LOAD)               v = 10'b0_0_00_1_0_0_0_0_0;
         else if (op == OP_BRANCH)             v = 10'b0_0_00_0_1_0_1_0_0;
         else if (op == OP_JAL)                v = 10'b1_0_10_0_1_0_1_0_0;
         else if (op == OP_JALR)               v = 10'b1_0_10_1_1_0_1_1_0;
         else                                  v = 10'b0_0_00_0_1_0_0_0_0;
      end
      else if (st == 3'd3)                     v = 10'b1_0_00_1_1_0_0_0_0;
      else if (st == 3'd7 && HALT_EN)          v = 10'b0_0_00_0_0_0_0_0_1;
      return v;
   endfunction

   function automatic logic [2:0] ref_next(input logic [2:0] st,
                                           input logic [6:0] op,
                                           input logic rn);
      case (st)
         3'd0: return rn ? 3'd1 : 3'd0;
         3'd1: return (!is_legal(op) && HALT_EN) ? 3'd7 : 3'd2;
         3'd2: return (op == OP_LOAD) ? 3'd3 : 3'd0;
         3'd7: return HALT_EN ? 3'd7 : 3'd0;
         default: return 3'd0;
      endcase
   endfunction

   task automatic step(input logic r, input logic rn, input logic [6:0] op);
      exp_t e, g;
      reset = r; run = rn; opcode = op;
      #1;
      e.st   = r ? 3'd0 : m_st;
      e.strb = r ? 10'b0 : ref_strb(m_st, op, rn);
      e.ins  = m_ins;
      exp_q.push_back(e);
      @(posedge CLK);
      g = exp_q.pop_front();
      check("state", {29'b0, state}, {29'b0, g.st});
      check("strobes", {22'b0, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel,
            load_pc, load_ir, pc_next_sel, pc_adder_sel, halted},
            {22'b0, g.strb});
      check("instret", 32'(instret), 32'(g.ins));
      if (r) begin
         m_st = 3'd0; m_ins = '0;
      end else begin
         m_ins = m_ins + W'(g.strb[4]);
         m_st  = ref_next(m_st, op, rn);
      end
      @(negedge CLK);
   endtask

   logic [6:0] ops [12];

   initial begin
      ops = '{OP_R, OP_R32, OP_IMM, OP_IMM32, OP_LUI, OP_AUIPC,
              OP_STORE, OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR, OP_ILL};
      m_st = 3'd0; m_ins = '0;
      @(negedge CLK);
      step(1, 0, OP_R);
      step(1, 1, OP_R);
      check("rst_state", 32'(state), 0);

      for (int i = 0; i < 3; i++) step(0, 1, OP_R);
      check("r_ret", 32'(instret), 1);

      step(1, 1, OP_LOAD);
      for (int i = 0; i < 20; i++) step(0, 1, OP_LOAD);
      check("load5", 32'(instret), 5);

      step(1, 1, OP_JALR);
      step(0, 1, OP_JALR);
      step(0, 1, OP_JALR);
      check("jalr_ex", {28'b0, WE_RF, pc_next_sel, pc_adder_sel,
            ULA_din2_sel}, 32'hF);
      step(0, 1, OP_JALR);

      for (int k = 0; k < 11; k++)
         for (int i = 0; i < 3 + (ops[k] == OP_LOAD ? 1 : 0); i++)
            step(0, 1, ops[k]);

      step(1, 0, OP_R);
      for (int i = 0; i < 5; i++) step(0, 0, OP_R);
      check("idle_ret", 32'(instret), 0);
      step(0, 1, OP_R);
      check("idle_dec", 32'(state), 1);
      step(0, 0, OP_R);
      step(0, 0, OP_R);
      check("run_late", 32'(instret), 1);

      step(1, 1, OP_ILL);
      for (int i = 0; i < 3; i++) step(0, 1, OP_ILL);
      if (HALT_EN) begin
         for (int i = 0; i < 10; i++) step(0, 1, OP_ILL);
         check("halt_st", 32'(state), 7);
         check("halt_ret", 32'(instret), 0);
         step(1, 1, OP_R);
         check("halt_rst", 32'(state), 0);
      end else begin
         check("nop_ret", 32'(instret), 1);
      end

      step(1, 1, OP_R);
      for (int i = 0; i < 3; i++) step(0, 1, OP_R);
      step(0, 1, OP_STORE);
      step(0, 1, OP_STORE);
      step(1, 1, OP_STORE);
      check("st_rst_s", 32'(state), 0);
      check("st_rst_i", 32'(instret), 0);

      for (int i = 0; i < 48; i++) step(0, 1, OP_R);
      check("wrap", 32'(instret), 0);

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
              ops[$urandom_range(0, 11)]);

      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
